// File: rtl/shift_add_multiplier_if.sv
// Multiply request/result bus plus the adder operand/sum wiring for shift_add_multiplier.
// The master side is the requester and also hosts the external carry-less adder.
interface shift_add_multiplier_if #(
    parameter int n = 8
);
    logic           start;
    logic [n-1:0]   mcand;
    logic [n-1:0]   mplier;
    logic [n-1:0]   add_a;
    logic [n-1:0]   add_b;
    logic [n-1:0]   add_s;
    logic           busy;
    logic           done;
    logic [2*n-1:0] product;

    modport master (
        output start, mcand, mplier, add_s,
        input  add_a, add_b, busy, done, product
    );

    modport slave (
        input  start, mcand, mplier, add_s,
        output add_a, add_b, busy, done, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned n x n -> 2n shift-add multiplier that borrows an external
// n-bit carry-less adder and rebuilds the lost carry-out from the operand/sum MSBs.
module shift_add_multiplier #(
    parameter int n  = 8,
    parameter int cw = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_add_multiplier_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [cw-1:0] last_cnt = cw'(n - 1);

    state_t        state_reg;
    logic [n-1:0]  acc_reg;
    logic [n-1:0]  q_reg;
    logic [n-1:0]  m_reg;
    logic [cw-1:0] cnt_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [n-1:0]  add_a_next;
    logic [n-1:0]  add_b_next;
    logic          carry;
    logic          accept;

    // Operands are only presented while iterating so the shared adder sees zeros otherwise.
    always_comb begin
        add_a_next = '0;
        add_b_next = '0;
        if (state_reg == RUN) begin
            add_a_next = acc_reg;
            add_b_next = q_reg[0] ? m_reg : '0;
        end
    end

    // Carry-out of a+b: both MSBs set, or exactly one set and the sum MSB cleared.
    assign carry = (add_a_next[n-1] & add_b_next[n-1])
                 | ((add_a_next[n-1] ^ add_b_next[n-1]) & ~bus.add_s[n-1]);

    assign accept = bus.start && (state_reg == IDLE || state_reg == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (accept) begin
                        m_reg     <= bus.mcand;
                        q_reg     <= bus.mplier;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    // Right shift of {carry, sum, q}: the sum LSB becomes a finished product bit.
                    acc_reg <= {carry, bus.add_s[n-1:1]};
                    q_reg   <= {bus.add_s[0], q_reg[n-1:1]};
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == last_cnt) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.add_a   = add_a_next;
    assign bus.add_b   = add_b_next;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.product = {acc_reg, q_reg};

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Multi-cycle unsigned n x n -> 2n multiplier. Sits directly upstream and downstream of the datapath's n-bit carry-less adder.
- Drives the adder's two operands each cycle, consumes its n-bit sum, and recovers the lost carry-out locally.
- Used by the ALU multiply path. The adder is external to this block and wired through the add_* ports.

Parameters:
- n, 8, operand width in bits; must be >= 2.
- cw, 4, iteration counter width; must satisfy 2^cw > n.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; honoured only in IDLE or DONE.
- mcand  input  n  multiplicand; sampled on an accepted start.
- mplier  input  n  multiplier; sampled on an accepted start.
- add_a  output  n  adder operand a (combinational from state).
- add_b  output  n  adder operand b (combinational from state).
- add_s  input  n  adder sum, returned combinationally in the same cycle.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse: product valid.
- product  output  2n  result; held until the next accepted start.

Behaviour:
- Registers:
  - acc[n-1:0]: upper partial product.
  - q[n-1:0]: multiplier / lower product.
  - m[n-1:0]: latched multiplicand.
  - cnt[cw-1:0]: iteration counter.
  - state: IDLE, RUN, DONE.
- Reset (rst_n low, asynchronous):
  - state=IDLE; acc, q, m, cnt = 0.
  - busy=0, done=0, product=0.
  - An operation in progress is abandoned with no done pulse.
  - Normal operation resumes on the first clk edge after rst_n rises.
- IDLE:
  - add_a=0, add_b=0.
  - On start=1: m<=mcand, q<=mplier, acc<=0, cnt<=0, state<=RUN.
- RUN (busy=1):
  - add_a=acc; add_b = q[0] ? m : 0.
  - Carry recovery: c = (add_a[n-1] & add_b[n-1]) | ((add_a[n-1] ^ add_b[n-1]) & ~add_s[n-1]).
  - Each edge: {acc,q} <= {c, add_s, q[n-1:1]} (2n+1 bits truncated to the low 2n, i.e. a right shift); cnt <= cnt+1.
  - When cnt == n-1 at the edge: state <= DONE.
  - Exactly n RUN cycles per operation.
  - start is ignored in RUN. Inputs mcand/mplier may change freely in RUN without effect.
- DONE (done=1 for exactly this one cycle, busy=0):
  - add_a=0, add_b=0.
  - Next edge: if start=1, behave as the IDLE accept (back-to-back, no bubble); else state <= IDLE.
- Outputs:
  - product = {acc,q}, continuously driven.
  - Valid in DONE and remains stable in IDLE until the next accept.
  - In RUN it shows intermediate values and must not be consumed.
- Latency: start accepted at edge E0; done high during the cycle after edge E0+n; total n+1 cycles start-to-done.
- Arithmetic: unsigned only; no overflow possible, since 2n bits hold the full product. Zero operands take the full n cycles (no early exit).

Test Plan:
- n=8, start with mcand=13, mplier=11 -> busy high 8 cycles, done pulses once, product=143 (0x008F), held afterwards.
- mcand=255, mplier=255 -> product=65025 (0xFE01); exercises carry recovery on every iteration.
- mcand=0, mplier=200 and mcand=200, mplier=0 -> product=0 after a full 8 RUN cycles; add_b=0 throughout the first case.
- Start at 7*9; pulse start with 3*3 and change mcand/mplier mid-RUN -> ignored, product=63.
- Hold start high through DONE with 6*7 then 10*10 -> second accept on the done edge, no IDLE cycle; products 42 then 100.
- Assert rst_n low at RUN cycle 4 of 100*100 -> immediate busy=0, product=0, no done; a following 2*3 yields 6.
